text_cursor_writer: RTL and testbench

//  Upstream feeder of the 7x20 character plane. Accepts a byte stream (keyboard/UART) over a

---
 rtl/text_cursor_writer.sv | 192 +++++++++++++++++++
 tb/tb_text_cursor_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_writer.sv
// text_cursor_writer: takes a byte stream over valid/ready and drives the
// character-plane write port. It keeps the text cursor and can sweep-clear
// the text area.
// Optional build macro STATUS_ECHO_EN: when it is defined, each printable
// byte is also written to the status cell in the following cycle.
module text_cursor_writer #(
  parameter int unsigned COLS      = 20,
  parameter int unsigned TEXT_ROWS = 6,
  parameter logic [7:0]  CLR_CODE  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       we,
  output logic [7:0] wdata,
  output logic [3:0] wrow,
  output logic [5:0] wcol,
  output logic       sel_status,
  output logic [3:0] cur_row,
  output logic [5:0] cur_col,
  output logic       busy
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(TEXT_ROWS - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;

`ifdef STATUS_ECHO_EN
  typedef enum logic [1:0] {IDLE, CLEAR, ECHO} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] col;
  } cell_t;

  state_t     state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] wrow_q, wrow_d;
  logic [5:0] wcol_q, wcol_d;
  logic       sel_status_q, sel_status_d;
  cell_t      cur_q, cur_d;
  cell_t      clr_q, clr_d;

  // Next cell in row-major order, wrapping from the last text cell to (0,0).
  function automatic cell_t adv_cell(input cell_t c);
    cell_t n;
    n = c;
    if (c.col == LAST_COL) begin
      n.col = '0;
      n.row = (c.row == LAST_ROW) ? '0 : c.row + 4'd1;
    end else begin
      n.col = c.col + 6'd1;
    end
    return n;
  endfunction

  // Previous cell in row-major order, pinned at (0,0).
  function automatic cell_t back_cell(input cell_t c);
    cell_t n;
    n = c;
    if (c.col != '0) begin
      n.col = c.col - 6'd1;
    end else if (c.row != '0) begin
      n.row = c.row - 4'd1;
      n.col = LAST_COL;
    end
    return n;
  endfunction

  // Start of the next line, wrapping past the last text row.
  function automatic cell_t line_feed(input cell_t c);
    cell_t n;
    n.col = '0;
    n.row = (c.row == LAST_ROW) ? '0 : c.row + 4'd1;
    return n;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wrow_q       <= '0;
      wcol_q       <= '0;
      sel_status_q <= 1'b0;
      cur_q        <= '0;
      clr_q        <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wrow_q       <= wrow_d;
      wcol_q       <= wcol_d;
      sel_status_q <= sel_status_d;
      cur_q        <= cur_d;
      clr_q        <= clr_d;
    end
  end

  // Byte decode, clear sweep and status echo; the write fields hold when idle.
  always_comb begin
    state_d      = state_q;
    we_d         = 1'b0;
    sel_status_d = 1'b0;
    wdata_d      = wdata_q;
    wrow_d       = wrow_q;
    wcol_d       = wcol_q;
    cur_d        = cur_q;
    clr_d        = clr_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            we_d    = 1'b1;
            wdata_d = in_data;
            wrow_d  = cur_q.row;
            wcol_d  = cur_q.col;
            cur_d   = adv_cell(cur_q);
`ifdef STATUS_ECHO_EN
            state_d = ECHO;
`endif
          end else if ((in_data == CH_LF) || (in_data == CH_CR)) begin
            cur_d = line_feed(cur_q);
          end else if (in_data == CH_BS) begin
            cur_d   = back_cell(cur_q);
            we_d    = 1'b1;
            wdata_d = CLR_CODE;
            wrow_d  = back_cell(cur_q).row;
            wcol_d  = back_cell(cur_q).col;
          end else if (in_data == CH_ESC) begin
            // Cell (0,0) is written on the accepting edge; the sweep pointer
            // then walks the remaining cells and wraps back to (0,0) at the end.
            state_d = CLEAR;
            we_d    = 1'b1;
            wdata_d = CLR_CODE;
            wrow_d  = '0;
            wcol_d  = '0;
            cur_d   = '0;
            clr_d   = adv_cell('0);
          end
        end
      end
      CLEAR: begin
        if (clr_q == '0) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          wdata_d = CLR_CODE;
          wrow_d  = clr_q.row;
          wcol_d  = clr_q.col;
          clr_d   = adv_cell(clr_q);
        end
      end
`ifdef STATUS_ECHO_EN
      ECHO: begin
        // wdata_q still holds the byte just written to the text plane.
        we_d         = 1'b1;
        sel_status_d = 1'b1;
        state_d      = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign we         = we_q;
  assign wdata      = wdata_q;
  assign wrow       = wrow_q;
  assign wcol       = wcol_q;
  assign sel_status = sel_status_q;
  assign cur_row    = cur_q.row;
  assign cur_col    = cur_q.col;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Self-checking bench for text_cursor_writer: a directed vector table, hand
// sequences for wrap/backspace/clear/reset-abort, then random traffic checked
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_text_cursor_writer;

  localparam int COLS  = 20;
  localparam int ROWS  = 6;
  localparam int NCELL = COLS * ROWS;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       we;
  logic [7:0] wdata;
  logic [3:0] wrow;
  logic [5:0] wcol;
  logic       sel_status;
  logic [3:0] cur_row;
  logic [5:0] cur_col;
  logic       busy;

  always #5 clk = ~clk;

  text_cursor_writer #(
    .COLS(20),
    .TEXT_ROWS(6),
    .CLR_CODE(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .we(we),
    .wdata(wdata),
    .wrow(wrow),
    .wcol(wcol),
    .sel_status(sel_status),
    .cur_row(cur_row),
    .cur_col(cur_col),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] d;
    logic [3:0] r;
    logic [5:0] c;
    logic       s;
  } wr_t;

  wr_t        pend[$];
  int         m_idx;     // linear cursor index row*COLS+col
  int         m_lock;    // cycles remaining with input blocked
  logic       m_we, m_sel;
  logic [7:0] m_wdata;
  logic [3:0] m_wrow;
  logic [5:0] m_wcol;

  task automatic push_wr(input logic [7:0] d, input int idx, input logic s);
    wr_t w;
    w.d = d;
    w.r = 4'(idx / COLS);
    w.c = 6'(idx % COLS);
    w.s = s;
    pend.push_back(w);
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(b, m_idx, 1'b0);
`ifdef STATUS_ECHO_EN
      push_wr(b, m_idx, 1'b1);
      m_lock = 1;
`endif
      m_idx = (m_idx + 1) % NCELL;
    end else if (b == 8'h0A || b == 8'h0D) begin
      m_idx = (((m_idx / COLS) + 1) % ROWS) * COLS;
    end else if (b == 8'h08) begin
      if (m_idx > 0) m_idx = m_idx - 1;
      push_wr(8'hFF, m_idx, 1'b0);
    end else if (b == 8'h1B) begin
      for (int k = 0; k < NCELL; k++) push_wr(8'hFF, k, 1'b0);
      m_lock = NCELL;
      m_idx  = 0;
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    logic rdy;
    wr_t  w;
    if (r) begin
      pend.delete();
      m_idx = 0; m_lock = 0;
      m_we = 1'b0; m_sel = 1'b0; m_wdata = '0; m_wrow = '0; m_wcol = '0;
      return;
    end
    rdy = (m_lock == 0);
    if (m_lock > 0) m_lock--;
    if (v && rdy) model_accept(d);
    if (pend.size() > 0) begin
      w = pend.pop_front();
      m_we = 1'b1; m_sel = w.s; m_wdata = w.d; m_wrow = w.r; m_wcol = w.c;
    end else begin
      m_we = 1'b0; m_sel = 1'b0;
    end
  endtask

  task automatic compare_model();
    chk("m_we", we, m_we);
    chk("m_sel_status", sel_status, m_sel);
    if (m_we) chk("m_wdata", wdata, m_wdata);
    chk("m_wrow", wrow, m_wrow);
    chk("m_wcol", wcol, m_wcol);
    chk("m_cur_row", cur_row, 32'(m_idx / COLS));
    chk("m_cur_col", cur_col, 32'(m_idx % COLS));
    chk("m_in_ready", in_ready, (m_lock == 0));
    chk("m_busy", busy, (m_lock != 0));
  endtask

  // Apply inputs, clock once, then compare after the edge has settled.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    reset = r; in_valid = v; in_data = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    compare_model();
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      step(1'b0, 1'b0, 8'h00);
      t++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1'b1);
    step(1'b0, 1'b1, b);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_we;
    logic [7:0] e_wd;
    int         e_wr, e_wc, e_cr, e_cc;
    logic       e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic e_we, input logic [7:0] e_wd,
                              input int e_wr, input int e_wc,
                              input int e_cr, input int e_cc, input logic e_rdy);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.e_we = e_we; x.e_wd = e_wd;
    x.e_wr = e_wr; x.e_wc = e_wc; x.e_cr = e_cr; x.e_cc = e_cc; x.e_rdy = e_rdy;
    return x;
  endfunction

  vec_t tbl[17];
  int   cnt;
  logic bad_order;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    m_idx = 0; m_lock = 0; m_we = 0; m_sel = 0; m_wdata = 0; m_wrow = 0; m_wcol = 0;

`ifndef STATUS_ECHO_EN
    //            r  v  data   we wdata  wr wc cr cc rdy
    tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, 8'h41, 1, 8'h41, 0, 0, 0, 1, 1);
    tbl[5]  = mk(0, 1, 8'h42, 1, 8'h42, 0, 1, 0, 2, 1);
    tbl[6]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 2, 1);
    tbl[7]  = mk(0, 1, 8'h0D, 0, 8'h00, 0, 1, 1, 0, 1);
    tbl[8]  = mk(0, 1, 8'h08, 1, 8'hFF, 0, 19, 0, 19, 1);
    tbl[9]  = mk(0, 1, 8'h07, 0, 8'h00, 0, 19, 0, 19, 1);
    tbl[10] = mk(0, 1, 8'h0A, 0, 8'h00, 0, 19, 1, 0, 1);
    tbl[11] = mk(0, 1, 8'h7A, 1, 8'h7A, 1, 0, 1, 1, 1);
    tbl[12] = mk(0, 1, 8'h7F, 0, 8'h00, 1, 0, 1, 1, 1);
    tbl[13] = mk(0, 1, 8'h20, 1, 8'h20, 1, 1, 1, 2, 1);
    tbl[14] = mk(0, 1, 8'h7E, 1, 8'h7E, 1, 2, 1, 3, 1);
    tbl[15] = mk(0, 1, 8'h1F, 0, 8'h00, 1, 2, 1, 3, 1);
    tbl[16] = mk(0, 0, 8'h51, 0, 8'h00, 1, 2, 1, 3, 1);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_we", i), we, tbl[i].e_we);
      if (tbl[i].e_we || tbl[i].r) chk($sformatf("tbl%0d_wdata", i), wdata, tbl[i].e_wd);
      chk($sformatf("tbl%0d_wrow", i), wrow, tbl[i].e_wr);
      chk($sformatf("tbl%0d_wcol", i), wcol, tbl[i].e_wc);
      chk($sformatf("tbl%0d_cur_row", i), cur_row, tbl[i].e_cr);
      chk($sformatf("tbl%0d_cur_col", i), cur_col, tbl[i].e_cc);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_sel_status", i), sel_status, 1'b0);
    end
`endif

    // 22 printable bytes from (0,0): byte 21 lands at (1,0), cursor ends at (1,2).
    do_reset();
    for (int i = 0; i < 22; i++) begin
      send(8'(8'h61 + i % 26));
      if (i == 20) begin
        chk("b21_we", we, 1'b1);
        chk("b21_wrow", wrow, 1);
        chk("b21_wcol", wcol, 0);
      end
    end
    chk("b22_cur_row", cur_row, 1);
    chk("b22_cur_col", cur_col, 2);

    // Last text cell: write at (5,19), cursor wraps to (0,0).
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h0D);
    for (int i = 0; i < 19; i++) send(8'h2E);
    chk("pre_wrap_row", cur_row, 5);
    chk("pre_wrap_col", cur_col, 19);
    send(8'h58);
    chk("wrap_we", we, 1'b1);
    chk("wrap_wdata", wdata, 8'h58);
    chk("wrap_wrow", wrow, 5);
    chk("wrap_wcol", wcol, 19);
    chk("wrap_cur_row", cur_row, 0);
    chk("wrap_cur_col", cur_col, 0);

    // Backspace across a row boundary, then at the origin.
    do_reset();
    send(8'h0A); send(8'h0A);
    send(8'h08);
    chk("bs_we", we, 1'b1);
    chk("bs_wdata", wdata, 8'hFF);
    chk("bs_wrow", wrow, 1);
    chk("bs_wcol", wcol, 19);
    chk("bs_cur_row", cur_row, 1);
    chk("bs_cur_col", cur_col, 19);
    do_reset();
    send(8'h08);
    chk("bs0_we", we, 1'b1);
    chk("bs0_wdata", wdata, 8'hFF);
    chk("bs0_wrow", wrow, 0);
    chk("bs0_wcol", wcol, 0);
    chk("bs0_cur_row", cur_row, 0);
    chk("bs0_cur_col", cur_col, 0);

    // Full clear sweep from a moved cursor.
    do_reset();
    send(8'h41); send(8'h0D); send(8'h42);
    send(8'h1B);
    cnt = 0; bad_order = 1'b0;
    for (int t = 0; t < 200 && !(in_ready && !we); t++) begin
      if (we) begin
        if (wrow !== 4'(cnt / COLS) || wcol !== 6'(cnt % COLS) || wdata !== 8'hFF)
          bad_order = 1'b1;
        chk("clr_in_ready_low", in_ready, 1'b0);
        cnt++;
      end
      step(1'b0, 1'b0, 8'h00);
    end
    chk("clr_order", bad_order, 1'b0);
    chk("clr_pulses", cnt, NCELL);
    chk("clr_cur_row", cur_row, 0);
    chk("clr_cur_col", cur_col, 0);
    chk("clr_ready_after", in_ready, 1'b1);

    // Reset after 50 sweep pulses: no further writes, back to idle.
    send(8'h1B);
    for (int i = 0; i < 49; i++) step(1'b0, 1'b0, 8'h00);
    chk("abort_50th_we", we, 1'b1);
    chk("abort_50th_wcol", wcol, 49 % COLS);
    step(1'b1, 1'b0, 8'h00);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (we) cnt++;
    end
    chk("abort_no_we", cnt, 0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);

`ifdef STATUS_ECHO_EN
    // Printable byte followed by its status-cell echo.
    do_reset();
    send(8'h5A);
    chk("echo1_we", we, 1'b1);
    chk("echo1_sel", sel_status, 1'b0);
    chk("echo1_wdata", wdata, 8'h5A);
    chk("echo1_in_ready", in_ready, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("echo2_we", we, 1'b1);
    chk("echo2_sel", sel_status, 1'b1);
    chk("echo2_wdata", wdata, 8'h5A);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic       r, v;
      logic [7:0] d;
      int unsigned sel;
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 70)      d = 8'($urandom_range(32'h20, 32'h7E));
      else if (sel < 78) d = (sel[0]) ? 8'h0A : 8'h0D;
      else if (sel < 88) d = 8'h08;
      else if (sel < 90) d = 8'h1B;
      else               d = 8'($urandom_range(0, 255));
      step(r, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
